// File: rtl/voice_allocator.sv
// Three-voice note allocator: each accepted note request is placed on a free voice, or steals
// the voice with the fewest beats left. Each voice keeps a remaining-beat counter that counts
// down on play-qualified beats.
module voice_allocator #(
  parameter int unsigned NOTE_W = 6,
  parameter int unsigned DUR_W  = 6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              play_i,
  input  logic              beat_i,
  input  logic              req_valid_i,
  input  logic [NOTE_W-1:0] req_note_i,
  input  logic [DUR_W-1:0]  req_duration_i,
  output logic              req_ready_o,
  output logic [NOTE_W-1:0] note0_o,
  output logic [NOTE_W-1:0] note1_o,
  output logic [NOTE_W-1:0] note2_o,
  output logic [DUR_W-1:0]  duration0_o,
  output logic [DUR_W-1:0]  duration1_o,
  output logic [DUR_W-1:0]  duration2_o,
  output logic              load0_o,
  output logic              load1_o,
  output logic              load2_o,
  output logic [2:0]        voice_active_o,
  output logic              steal_o
);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e            state_q, state_d;
  logic [DUR_W-1:0]  rem_q  [3];
  logic [DUR_W-1:0]  rem_d  [3];
  logic [NOTE_W-1:0] note_q [3];
  logic [NOTE_W-1:0] note_d [3];
  logic [DUR_W-1:0]  dur_q  [3];
  logic [DUR_W-1:0]  dur_d  [3];
  logic [1:0]        sel_q, sel_d;
  logic              steal_q, steal_d;

  logic              accept, issue, tick;
  logic [1:0]        pick;
  logic              pick_steal;
  logic [DUR_W-1:0]  min_rem;

  assign req_ready_o = (state_q == StIdle) && !flush_i && !reset_i;
  assign accept      = req_valid_i && req_ready_o;
  // Rests and zero-length notes are consumed without touching any voice.
  assign issue       = accept && (req_note_i != '0) && (req_duration_i != '0);
  assign tick        = beat_i && play_i;

  // Victim choice: lowest-index idle voice, else the voice with the fewest beats left.
  always_comb begin
    pick       = 2'd0;
    pick_steal = 1'b1;
    min_rem    = rem_q[0];
    for (int k = 2; k >= 0; k--) begin
      if (rem_q[k] == '0) begin
        pick       = 2'(k);
        pick_steal = 1'b0;
      end
    end
    if (pick_steal) begin
      pick = 2'd0;
      for (int k = 1; k < 3; k++) begin
        if (rem_q[k] < min_rem) begin
          min_rem = rem_q[k];
          pick    = 2'(k);
        end
      end
    end
  end

  // Next-state for the FSM and per-voice counters, notes and durations.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    steal_d = steal_q;
    for (int k = 0; k < 3; k++) begin
      note_d[k] = note_q[k];
      dur_d[k]  = dur_q[k];
      rem_d[k]  = rem_q[k];
      if (tick && rem_q[k] != '0) rem_d[k] = rem_q[k] - 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          state_d      = StIssue;
          sel_d        = pick;
          steal_d      = pick_steal;
          note_d[pick] = req_note_i;
          dur_d[pick]  = req_duration_i;
          // A load on a beat edge takes the full duration, no decrement.
          rem_d[pick]  = req_duration_i;
        end
      end
      StIssue: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush_i) begin
      state_d = StIdle;
      for (int k = 0; k < 3; k++) rem_d[k] = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      sel_q   <= 2'd0;
      steal_q <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        rem_q[k]  <= '0;
        note_q[k] <= '0;
        dur_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      steal_q <= steal_d;
      for (int k = 0; k < 3; k++) begin
        rem_q[k]  <= rem_d[k];
        note_q[k] <= note_d[k];
        dur_q[k]  <= dur_d[k];
      end
    end
  end

  logic strobe;
  // Strobes only in ISSUE; reset or flush in that cycle cancels them.
  assign strobe  = (state_q == StIssue) && !reset_i && !flush_i;
  assign load0_o = strobe && (sel_q == 2'd0);
  assign load1_o = strobe && (sel_q == 2'd1);
  assign load2_o = strobe && (sel_q == 2'd2);
  assign steal_o = strobe && steal_q;

  // Outputs read as zero while reset is held.
  always_comb begin
    for (int k = 0; k < 3; k++) voice_active_o[k] = !reset_i && (rem_q[k] != '0);
  end
  assign note0_o     = reset_i ? '0 : note_q[0];
  assign note1_o     = reset_i ? '0 : note_q[1];
  assign note2_o     = reset_i ? '0 : note_q[2];
  assign duration0_o = reset_i ? '0 : dur_q[0];
  assign duration1_o = reset_i ? '0 : dur_q[1];
  assign duration2_o = reset_i ? '0 : dur_q[2];

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios followed by random traffic, all checked
// against a behavioural voice model.
module tb_voice_allocator;
  localparam int NW = 6;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          reset, flush, play, beat, req_valid;
  logic [NW-1:0] req_note;
  logic [DW-1:0] req_duration;
  logic          req_ready, load0, load1, load2, steal;
  logic [NW-1:0] note0, note1, note2;
  logic [DW-1:0] duration0, duration1, duration2;
  logic [2:0]    voice_active;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: beats left, note and length per voice, plus the pending strobe.
  int m_rem  [3];
  int m_note [3];
  int m_dur  [3];
  bit m_issue;
  bit m_steal;
  int m_sel;

  always #5 clk = ~clk;

  voice_allocator #(.NOTE_W(NW), .DUR_W(DW)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .flush_i        (flush),
    .play_i         (play),
    .beat_i         (beat),
    .req_valid_i    (req_valid),
    .req_note_i     (req_note),
    .req_duration_i (req_duration),
    .req_ready_o    (req_ready),
    .note0_o        (note0),
    .note1_o        (note1),
    .note2_o        (note2),
    .duration0_o    (duration0),
    .duration1_o    (duration1),
    .duration2_o    (duration2),
    .load0_o        (load0),
    .load1_o        (load1),
    .load2_o        (load2),
    .voice_active_o (voice_active),
    .steal_o        (steal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare outputs to model, advance model at posedge.
  task automatic step(input bit r, input bit f, input bit p, input bit b, input bit v,
                      input int n, input int d);
    bit              e_ready, go, any_free;
    logic [2:0]      e_load, e_va;
    logic [3*NW-1:0] e_note;
    logic [3*DW-1:0] e_dur;
    int              s;
    @(negedge clk);
    reset = r; flush = f; play = p; beat = b; req_valid = v;
    req_note = NW'(n); req_duration = DW'(d);
    #1;
    e_ready = !r && !f && !m_issue;
    for (int k = 0; k < 3; k++) begin
      e_load[k] = !r && !f && m_issue && (m_sel == k);
      e_va[k]   = !r && (m_rem[k] > 0);
      e_note[k*NW +: NW] = r ? '0 : NW'(m_note[k]);
      e_dur[k*DW +: DW]  = r ? '0 : DW'(m_dur[k]);
    end
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("load", 32'({load2, load1, load0}), 32'(e_load));
    chk("steal", 32'(steal), 32'(!r && !f && m_issue && m_steal));
    chk("voice_active", 32'(voice_active), 32'(e_va));
    chk("notes", 32'({note2, note1, note0}), 32'(e_note));
    chk("durations", 32'({duration2, duration1, duration0}), 32'(e_dur));
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 3; k++) begin m_rem[k] = 0; m_note[k] = 0; m_dur[k] = 0; end
      m_issue = 0; m_steal = 0; m_sel = 0;
    end else if (f) begin
      for (int k = 0; k < 3; k++) m_rem[k] = 0;
      m_issue = 0;
    end else begin
      go = v && e_ready && (n % (1 << NW) != 0) && (d % (1 << DW) != 0);
      s = -1;
      for (int k = 2; k >= 0; k--) if (m_rem[k] == 0) s = k;
      any_free = (s >= 0);
      if (!any_free) begin
        s = 0;
        for (int k = 1; k < 3; k++) if (m_rem[k] < m_rem[s]) s = k;
      end
      for (int k = 0; k < 3; k++) begin
        if (go && k == s) m_rem[k] = d;
        else if (p && b && m_rem[k] > 0) m_rem[k] = m_rem[k] - 1;
      end
      if (go) begin
        m_note[s] = n; m_dur[s] = d; m_sel = s; m_steal = !any_free;
      end
      m_issue = go;
    end
  endtask

  task automatic idle(input bit p, input bit b);
    step(0, 0, p, b, 0, 0, 0);
  endtask

  task automatic req(input int n, input int d);
    step(0, 0, 0, 0, 1, n, d);
    idle(0, 0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin m_rem[k] = 0; m_note[k] = 0; m_dur[k] = 0; end
    m_issue = 0; m_steal = 0; m_sel = 0;

    // Reset, then fill all three voices.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    req(10, 4); req(20, 5); req(30, 6);
    #1 chk("fill_active", 32'(voice_active), 32'h7);

    // Steal: rem {6,3,3}, request (40,2) lands on voice 1.
    step(1, 0, 0, 0, 0, 0, 0);
    req(1, 6); req(2, 3); req(3, 3);
    step(0, 0, 0, 0, 1, 40, 2);
    #1;
    chk("steal_load1", 32'({load2, load1, load0}), 32'h2);
    chk("steal_pulse", 32'(steal), 32'h1);
    chk("steal_note1", 32'(note1), 32'd40);
    idle(0, 0);
    idle(1, 1);
    idle(1, 1);
    #1 chk("steal_rem1_done", 32'(voice_active), 32'h5);

    // Countdown on voice 0 with saturation.
    step(1, 0, 0, 0, 0, 0, 0);
    req(7, 2);
    idle(1, 1);
    #1 chk("count_b1", 32'(voice_active[0]), 32'h1);
    idle(1, 1);
    #1 chk("count_b2", 32'(voice_active[0]), 32'h0);
    idle(1, 1);
    idle(0, 0);

    // Load coincident with a beat.
    step(1, 0, 0, 0, 0, 0, 0);
    req(1, 1); req(2, 4);
    idle(1, 1);
    step(0, 0, 1, 1, 1, 9, 5);
    #1 chk("simul_active", 32'(voice_active), 32'h3);
    idle(1, 1); idle(1, 1);
    #1 chk("simul_v1_done", 32'(voice_active), 32'h1);

    // Rest and zero-duration requests are dropped.
    step(0, 0, 0, 0, 1, 0, 4);
    #1 chk("rest_ready", 32'(req_ready), 32'h1);
    step(0, 0, 0, 0, 1, 5, 0);
    #1 chk("drop_ready", 32'(req_ready), 32'h1);

    // Flush with all voices active, then beats while paused.
    req(11, 9); req(12, 9); req(13, 9);
    step(0, 1, 1, 1, 1, 14, 3);
    #1 chk("flush_active", 32'(voice_active), 32'h0);
    req(15, 5);
    idle(0, 1); idle(0, 1);
    #1 chk("pause_hold", 32'(voice_active), 32'h1);

    // Reset while a load is pending.
    step(0, 0, 0, 0, 1, 16, 3);
    step(1, 0, 0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 60) == 0, ($urandom % 40) == 0, $urandom % 4 != 0, $urandom % 2 == 1,
           $urandom % 3 != 0,
           ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, 63)),
           ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 10)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
- REQ-001 Parameter NOTE_W, default 6: note field width.
- REQ-002 Parameter DUR_W, default 6: duration field width, in beats.
- REQ-003 Port clk  in  1: single clock; all state changes on the rising edge.
- REQ-004 Port reset  in  1: synchronous, active-high reset.
- REQ-005 Port flush  in  1: synchronous clear of voice state on song change or restart; lower priority than reset.
- REQ-006 Port play  in  1: beat countdown enable.
- REQ-007 Port beat  in  1: one-cycle beat pulse.
- REQ-008 Port req_valid  in  1: note request present.
- REQ-009 Port req_note  in  NOTE_W: requested note; 0 means rest.
- REQ-010 Port req_duration  in  DUR_W: requested length in beats.
- REQ-011 Port req_ready  out  1: request is accepted when req_valid and req_ready are both 1 in the same cycle.
- REQ-012 Port note0/note1/note2  out  NOTE_W each: registered note for each voice.
- REQ-013 Port duration0/duration1/duration2  out  DUR_W each: registered duration for each voice.
- REQ-014 Port load0/load1/load2  out  1 each: one-cycle load strobe for each voice.
- REQ-015 Port voice_active  out  3: bit k is 1 when voice k's remaining-beat count is nonzero.
- REQ-016 Port steal  out  1: one-cycle pulse, coincident with the load strobe, when an active voice is pre-empted.

Function
- REQ-017 The block shall track a DUR_W-bit remaining-beat counter rem[k] for each of the 3 voices.
- REQ-018 FSM states shall be IDLE and ISSUE; req_ready shall be 1 only in IDLE, and only when flush is 0.
- REQ-019 IDLE to ISSUE: a request shall be accepted whose req_note is nonzero and whose req_duration is nonzero.
- REQ-020 A request with req_note of 0 or req_duration of 0 shall be accepted and dropped: the FSM stays in IDLE, and no load or steal is issued.
- REQ-021 On an accepted, non-dropped request the target voice shall be selected as follows, on the registered rem values:
  - the lowest-index voice with rem of 0;
  - otherwise, the voice with the smallest rem, with ties going to the lowest index; steal shall be recorded.
- REQ-022 On the accept edge, the selected voice's note, duration and rem shall be loaded from the request, and the FSM shall enter ISSUE.
- REQ-023 In ISSUE, exactly one of load0/load1/load2 shall be 1, for the selected voice; steal shall be 1 if recorded; the FSM shall return to IDLE on the next edge.
- REQ-024 Latency from accept to load strobe shall be 1 cycle; maximum throughput shall be one request per 2 cycles.
- REQ-025 When beat is 1 and play is 1, each rem[k] that is nonzero shall decrement by 1, saturating at 0.
- REQ-026 When a voice is loaded on the same edge as a beat, that voice shall take req_duration with no decrement; the other voices shall decrement normally.
- REQ-027 When play is 0, rem shall hold; requests shall still be accepted and issued.
- REQ-028 note and duration outputs shall hold their values until that voice is next loaded.
- REQ-029 flush shall zero all rem, force the FSM to IDLE, and suppress any pending load and steal on that edge; note and duration outputs shall hold.
- REQ-030 voice_active shall be derived from the registered rem values only.

Reset
- REQ-031 When reset is 1, the FSM shall be IDLE, all rem shall be 0, and all note, duration, load and steal outputs shall be 0.
- REQ-032 Outputs while reset is 1 shall be: req_ready 0, voice_active 3'b000.
- REQ-033 On the first cycle after reset is deasserted, req_ready shall be 1.
- REQ-034 Reset while the FSM is in ISSUE shall cancel the load strobe.

Verification
- REQ-035 Fill: after reset, requests (note 10, dur 4), (20, 5), (30, 6), spaced 2 cycles apart -> load0, load1 and load2 fire in order; voice_active becomes 3'b111; steal stays 0.
- REQ-036 Steal: with rem = {6,3,3}, a request (40, 2) -> load1 fires, steal is 1, note1 = 40, rem1 = 2.
- REQ-037 Countdown: voice0 loaded with dur 2, play 1, two beat pulses -> voice_active[0] falls after the second beat; a third beat leaves rem0 at 0.
- REQ-038 Simultaneous: an accept targeting voice0 coincides with beat; voice1 has rem 3 -> rem0 equals the requested duration, rem1 = 2.
- REQ-039 Rest and drop: request (0, 4), then request (5, 0) -> both accepted, no load strobes, req_ready stays 1.
- REQ-040 Flush and hold: flush pulsed with all voices active -> voice_active is 3'b000 the next cycle; with play 0 and beats applied, rem is unchanged.
